// File: rtl/converter_arbiter.sv
// ============================================================================
// Module   : converter_arbiter
// Brief    : Round-robin arbiter for four 16-bit requesters, followed by a
//            highest-set-bit -> gray -> one-hot conversion of the captured word.
// Optional : define CONV_ARB_DONE_COUNT_EN to add the done_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module converter_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [63:0] req_data,
  output logic [3:0]  gnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_id,
  output logic        out_zero,
  output logic        busy
`ifdef CONV_ARB_DONE_COUNT_EN
  ,
  output logic [15:0] done_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [15:0] r_word;
  logic [3:0]  r_gnt;
  logic        r_valid;
  logic [15:0] r_data;
  logic [1:0]  r_id;
  logic        r_zero;

  logic [1:0]  w_sel_id;
  logic [1:0]  w_idx;
  logic [3:0]  w_b;
  logic [3:0]  w_gray;
  logic [15:0] w_onehot;

  // Descending offset scan so the requester closest after r_ptr wins.
  always_comb begin
    w_sel_id = 2'd0;
    w_idx    = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) w_sel_id = w_idx;
    end
  end

  // Zero word naturally falls out as b = 0.
  always_comb begin
    w_b = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (r_word[k]) w_b = 4'(k);
    end
    w_gray   = w_b ^ (w_b >> 1);
    w_onehot = 16'h0001 << w_gray;
  end

`ifdef CONV_ARB_DONE_COUNT_EN
  logic [15:0] r_done_count;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd3;
      r_word  <= 16'h0000;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_data  <= 16'h0000;
      r_id    <= 2'd0;
      r_zero  <= 1'b0;
`ifdef CONV_ARB_DONE_COUNT_EN
      r_done_count <= 16'h0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt <= 4'b0000;
          if (|req) begin
            r_gnt   <= 4'b0001 << w_sel_id;
            r_word  <= req_data[{w_sel_id, 4'b0000} +: 16];
            r_id    <= w_sel_id;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_gnt   <= 4'b0000;
          r_data  <= w_onehot;
          r_zero  <= (r_word == 16'h0000);
          r_valid <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_gnt <= 4'b0000;
          if (out_ready) begin
            r_valid <= 1'b0;
            r_ptr   <= r_id;
            r_state <= S_IDLE;
`ifdef CONV_ARB_DONE_COUNT_EN
            r_done_count <= r_done_count + 16'd1;
`endif
          end
        end
        default: begin
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign out_zero  = r_zero;
  assign busy      = (r_state != S_IDLE);
`ifdef CONV_ARB_DONE_COUNT_EN
  assign done_count = r_done_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_converter_arbiter.sv
// ============================================================================
// Module   : tb_converter_arbiter
// Brief    : Self-checking bench for converter_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_converter_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_id;
  logic        out_zero;
  logic        busy;
`ifdef CONV_ARB_DONE_COUNT_EN
  logic [15:0] done_count;
`endif

  converter_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_zero  (out_zero),
    .busy      (busy)
`ifdef CONV_ARB_DONE_COUNT_EN
    ,
    .done_count(done_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = waiting for a request, 1 = word captured,
  // 2 = result offered to the consumer.
  int          m_phase;
  int          m_ptr;
  int          m_id;
  logic [15:0] m_word;
  logic [3:0]  m_gnt;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_zero;
  int          m_done;

  function automatic logic [15:0] conv(input logic [15:0] w);
    int b;
    int g;
    if (w == 16'h0000) b = 0;
    else b = $clog2(int'(w) + 1) - 1;
    g = b ^ (b >> 1);
    return 16'(1 << g);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 3;
    m_id    = 0;
    m_word  = 16'h0000;
    m_gnt   = 4'b0000;
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_zero  = 1'b0;
    m_done  = 0;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        m_gnt = 4'b0000;
        if (req != 4'b0000) begin
          for (int off = 4; off >= 1; off--)
            if (req[(m_ptr + off) % 4]) m_id = (m_ptr + off) % 4;
          m_gnt   = 4'(1 << m_id);
          m_word  = req_data[m_id*16 +: 16];
          m_phase = 1;
        end
      end
      1: begin
        m_gnt   = 4'b0000;
        m_valid = 1'b1;
        m_data  = conv(m_word);
        m_zero  = (m_word == 16'h0000);
        m_phase = 2;
      end
      default: begin
        m_gnt = 4'b0000;
        if (out_ready) begin
          m_valid = 1'b0;
          m_ptr   = m_id;
          m_phase = 0;
          m_done  = (m_done + 1) % 65536;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id", 32'(out_id), 32'(m_id));
      chk("out_zero", 32'(out_zero), 32'(m_zero));
    end
`ifdef CONV_ARB_DONE_COUNT_EN
    chk("done_count", 32'(done_count), 32'(m_done));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_zero", 32'(out_zero), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
  endtask

  int          gcyc[$];
  int          gid[$];
  logic [15:0] held_data;

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    req_data  = 64'h0;
    out_ready = 1'b1;
    model_reset();

    // Pin the model's conversion against hand-worked values.
    chk("conv_0010", 32'(conv(16'h0010)), 32'h0040);
    chk("conv_8001", 32'(conv(16'h8001)), 32'h0100);
    chk("conv_0000", 32'(conv(16'h0000)), 32'h0001);
    chk("conv_ffff", 32'(conv(16'hFFFF)), 32'h0100);

    @(negedge clk);
    do_reset();

    // Single request, word 0x0010.
    req      = 4'b0001;
    req_data = 64'h0000_0000_0000_0010;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'h0040);
    chk("t1_id", 32'(out_id), 32'h0);
    chk("t1_zero", 32'(out_zero), 32'h0);
    step();
    chk("t1_done", 32'(out_valid), 32'h0);
    step();
    chk("t1_idle_gnt", 32'(gnt), 32'h0);

    // Round-robin with all requesters held.
    do_reset();
    req      = 4'b1111;
    req_data = {$urandom, $urandom};
    for (int c = 0; c < 15; c++) begin
      step();
      if (gnt != 4'b0000) begin
        gcyc.push_back(c);
        gid.push_back($clog2(int'(gnt)));
      end
    end
    chk("rr_count_ge5", 32'(gid.size() >= 5), 32'h1);
    if (gid.size() >= 5) begin
      chk("rr_id0", 32'(gid[0]), 32'd0);
      chk("rr_id1", 32'(gid[1]), 32'd1);
      chk("rr_id2", 32'(gid[2]), 32'd2);
      chk("rr_id3", 32'(gid[3]), 32'd3);
      chk("rr_id4", 32'(gid[4]), 32'd0);
      for (int i = 0; i < 4; i++)
        chk("rr_spacing", 32'(gcyc[i+1] - gcyc[i]), 32'd3);
    end

    // Boundary words: 0x8001 and zero.
    do_reset();
    req      = 4'b0100;
    req_data = 64'h0000_8001_0000_0000;
    step(); req = 4'b0000; step();
    chk("w8001_data", 32'(out_data), 32'h0100);
    chk("w8001_zero", 32'(out_zero), 32'h0);
    step();
    req      = 4'b1000;
    req_data = 64'h0000_FFFF_FFFF_FFFF;
    step(); req = 4'b0000; step();
    chk("w0000_data", 32'(out_data), 32'h0001);
    chk("w0000_zero", 32'(out_zero), 32'h1);
    chk("w0000_id", 32'(out_id), 32'd3);
    step();

    // Back-pressure in HOLD.
    req       = 4'b1111;
    req_data  = {$urandom, $urandom};
    out_ready = 1'b0;
    step(); step();
    held_data = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data", 32'(out_data), 32'(held_data));
      chk("bp_gnt", 32'(gnt), 32'h0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", 32'(out_valid), 32'h0);

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    step(); step(); step();
    chk("ar_in_hold", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    req       = 4'b1010;
    out_ready = 1'b1;
    step();
    chk("ar_first_gnt", 32'(gnt), 32'h2);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req       = 4'($urandom);
      req_data  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) req_data[16*$urandom_range(0, 3) +: 16] = 16'h0000;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/converter_arbiter.md
CONVERTER_ARBITER -- requirements
Module: converter_arbiter

Interface
REQ-001 The block SHALL have no parameters; it serves four requesters with 16-bit words.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  per-requester request; bit k belongs to requester k.
REQ-005 req_data  input  64  packed request words; requester k SHALL use bits [16k+15:16k].
REQ-006 gnt  output  4  one-hot, one-cycle acknowledge that requester k's word was captured.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-009 out_data  output  16  one-hot converted result.
REQ-010 out_id  output  2  index of the requester that owns out_data.
REQ-011 out_zero  output  1  captured word was 0x0000.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, CONV, HOLD.
REQ-014 IDLE: on an edge with req != 0, the block SHALL select the first set req bit, searching from ptr+1 upward and wrapping modulo 4.
- Same edge: capture that word, register gnt one-hot for exactly one cycle, store its id, go to CONV.
REQ-015 IDLE with req == 0: the block SHALL remain in IDLE, and gnt SHALL be 0.
REQ-016 CONV: the block SHALL compute the conversion and register it into out_data/out_zero, set out_valid, and go to HOLD.
- Conversion: b = index of highest set bit of the word (0..15).
- g = b XOR (b >> 1), 4-bit gray.
- out_data = 1 << g.
REQ-017 A zero word SHALL give b = 0, out_data = 0x0001, and out_zero = 1; otherwise out_zero = 0.
REQ-018 HOLD: out_valid, out_data, out_id and out_zero SHALL stay stable until an edge with out_ready = 1.
- On that edge: clear out_valid, set ptr = out_id, return to IDLE.
REQ-019 No request SHALL be sampled or granted outside IDLE; req changes in CONV/HOLD SHALL be ignored.
REQ-020 Minimum latency: req sampled at edge N, then gnt high after edge N, then out_valid high after edge N+1.
- Throughput SHALL be at most one transaction per 3 cycles with out_ready tied high.
REQ-021 A requester that deasserts req before being sampled in IDLE SHALL NOT be served.
REQ-022 Simultaneous requests SHALL be served strictly round-robin; a continuously asserting requester SHALL wait at most 3 transactions.

Reset
REQ-023 While rst_n = 0, the block SHALL force the following regardless of clk:
- state = IDLE
- ptr = 3, so requester 0 has first priority
- gnt = 0, out_valid = 0, out_data = 0x0000, out_id = 0, out_zero = 0, busy = 0
REQ-024 Reset asserted mid-transaction (CONV or HOLD) SHALL discard the transaction without a completion.

Configuration
REQ-025 With macro CONV_ARB_DONE_COUNT_EN defined, the block SHALL add output done_count (16 bits).
- Reset value 0.
- Increments on every out_valid && out_ready edge.
- Wraps from 0xFFFF to 0x0000.
REQ-026 Without CONV_ARB_DONE_COUNT_EN, the done_count port and its register SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then req=0001, word0=0x0010, out_ready=1:
- gnt=0001 for one cycle.
- Next cycle: out_valid=1, out_data=0x0040, out_id=0, out_zero=0.
REQ-028 After reset, req=1111 held, out_ready=1:
- out_id sequence 0,1,2,3,0.
- gnt pulses spaced 3 cycles apart.
REQ-029 Word 0x8001 -> out_data=0x0100. Word 0x0000 -> out_data=0x0001, out_zero=1.
REQ-030 out_ready=0 for 5 cycles in HOLD, req=1111:
- out_valid stays 1, outputs unchanged, gnt=0 throughout.
- Completes on the first cycle with out_ready=1.
REQ-031 rst_n pulled low in HOLD, asynchronously to clk:
- out_valid and busy fall immediately.
- After release with req=1010: requester 1 is granted first.
REQ-032 With CONV_ARB_DONE_COUNT_EN:
- 3 completions -> done_count=3.
- Preloaded at 0xFFFF plus one completion -> 0x0000.
- Rebuild without the macro: no done_count port.
